digit_step_ctrl: RTL

//   Upstream stage of the two-digit mm/ss adder. Synchronises and debounces the raw

---
 rtl/digit_step_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/digit_step_ctrl.sv
// Button front end and BCD digit stepper for one mm/ss field: it synchronises and debounces
// the buttons, runs press/hold/auto-repeat, and emits step and carry/borrow pulses.
module digit_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter int UNITS_MAX       = 9,
  parameter int TENS_MAX        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       add_pulse,
  output logic       sub_pulse,
  output logic       carry,
  output logic       borrow
);

  localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_RATE) ? CNT_MAX_A : REPEAT_RATE;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [3:0]    UMAX     = 4'(UNITS_MAX);
  localparam logic [3:0]    TMAX     = 4'(TENS_MAX);

  typedef enum logic [1:0] {DIR_NONE, DIR_INC, DIR_DEC} dir_t;
  typedef enum logic [1:0] {IDLE, FIRE, WAIT, RPT} state_t;

  logic          inc_p0, inc_p1, dec_p0, dec_p1;
  logic [CW-1:0] inc_cnt, dec_cnt;
  logic          deb_inc, deb_dec;
  dir_t          dir, held_dir;
  state_t        state;
  logic [CW-1:0] rpt_cnt;
  logic          step_req, step_up;
  logic [8:0]    step_res;

  function automatic logic [3:0] clamp_u(input logic [3:0] u);
    return (u > UMAX) ? UMAX : u;
  endfunction

  function automatic logic [3:0] clamp_t(input logic [3:0] t);
    return (t > TMAX) ? TMAX : t;
  endfunction

  // Result packed as {wrap, tens, units}; out-of-range digits step as if at max.
  function automatic logic [8:0] inc_step(input logic [3:0] t, input logic [3:0] u);
    logic [3:0] tc, uc;
    tc = clamp_t(t);
    uc = clamp_u(u);
    if (uc < UMAX)      return {1'b0, tc, uc + 4'd1};
    else if (tc < TMAX) return {1'b0, tc + 4'd1, 4'd0};
    else                return {1'b1, 4'd0, 4'd0};
  endfunction

  function automatic logic [8:0] dec_step(input logic [3:0] t, input logic [3:0] u);
    logic [3:0] tc, uc;
    tc = clamp_t(t);
    uc = clamp_u(u);
    if (uc != 4'd0)      return {1'b0, tc, uc - 4'd1};
    else if (tc != 4'd0) return {1'b0, tc - 4'd1, UMAX};
    else                 return {1'b1, TMAX, UMAX};
  endfunction

  // Synchroniser and debouncer stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_p0  <= 1'b0;
      inc_p1  <= 1'b0;
      dec_p0  <= 1'b0;
      dec_p1  <= 1'b0;
      inc_cnt <= '0;
      dec_cnt <= '0;
      deb_inc <= 1'b0;
      deb_dec <= 1'b0;
    end else begin
      inc_p0 <= btn_inc;
      inc_p1 <= inc_p0;
      dec_p0 <= btn_dec;
      dec_p1 <= dec_p0;
      if (inc_p1 == deb_inc) inc_cnt <= '0;
      else if (inc_cnt == DEB_LAST) begin
        deb_inc <= inc_p1;
        inc_cnt <= '0;
      end else inc_cnt <= inc_cnt + ONE;
      if (dec_p1 == deb_dec) dec_cnt <= '0;
      else if (dec_cnt == DEB_LAST) begin
        deb_dec <= dec_p1;
        dec_cnt <= '0;
      end else dec_cnt <= dec_cnt + ONE;
    end
  end

  always_comb begin
    dir = DIR_NONE;
    if (deb_inc && !deb_dec)      dir = DIR_INC;
    else if (deb_dec && !deb_inc) dir = DIR_DEC;
  end

  always_comb begin
    step_req = 1'b0;
    step_up  = 1'b0;
    case (state)
      IDLE: begin
        step_req = (dir != DIR_NONE);
        step_up  = (dir == DIR_INC);
      end
      WAIT: begin
        step_req = (dir == held_dir) && (rpt_cnt == DLY_LAST);
        step_up  = (held_dir == DIR_INC);
      end
      RPT: begin
        step_req = (dir == held_dir) && (rpt_cnt == RPT_LAST);
        step_up  = (held_dir == DIR_INC);
      end
      default: begin
        step_req = 1'b0;
        step_up  = 1'b0;
      end
    endcase
    step_res = step_up ? inc_step(tens, units) : dec_step(tens, units);
  end

  // Hold/repeat FSM and digit register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      held_dir  <= DIR_NONE;
      rpt_cnt   <= '0;
      tens      <= 4'd0;
      units     <= 4'd0;
      add_pulse <= 1'b0;
      sub_pulse <= 1'b0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
    end else begin
      add_pulse <= 1'b0;
      sub_pulse <= 1'b0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      case (state)
        IDLE: if (dir != DIR_NONE) begin
          state    <= FIRE;
          held_dir <= dir;
          rpt_cnt  <= '0;
        end
        // The FIRE cycle already counts as the first held cycle of the repeat delay.
        FIRE: begin
          rpt_cnt <= ONE;
          state   <= WAIT;
        end
        WAIT: if (dir != held_dir) begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end else if (rpt_cnt == DLY_LAST) begin
          state   <= RPT;
          rpt_cnt <= '0;
        end else rpt_cnt <= rpt_cnt + ONE;
        RPT: if (dir != held_dir) begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end else if (rpt_cnt == RPT_LAST) rpt_cnt <= '0;
        else rpt_cnt <= rpt_cnt + ONE;
        default: state <= IDLE;
      endcase
      if (load) begin
        tens  <= clamp_t(load_tens);
        units <= clamp_u(load_units);
      end else if (step_req) begin
        tens      <= step_res[7:4];
        units     <= step_res[3:0];
        add_pulse <= step_up;
        sub_pulse <= !step_up;
        carry     <= step_up && step_res[8];
        borrow    <= !step_up && step_res[8];
      end
    end
  end

endmodule
